// File: rtl/factor_search_ctrl.sv
// factor_search_ctrl
//   Skolem-witness generator for the combinational factorization checker
//   (res = (i1*i2 == o)). It captures a target product and walks every
//   candidate pair (i1, i2) in outer/inner order, with i2 varying fastest.
//   One candidate is presented per cycle. The search stops at the first
//   accepted pair, or after the last index.
//
//   Optional feature macro: FACTOR_SKIP_TRIVIAL_EN
//     defined   -> candidates with i1==1 or i2==1 are presented but not
//                  evaluated. chk_res is ignored for them and tries does not
//                  count them, so only nontrivial factorizations are reported.
//     undefined -> every candidate is evaluated.
//
//   Handshake: start is a request level that is sampled only in IDLE
//   (busy=0, done=0). It is accepted on that rising edge, and o_in is
//   captured at the same edge. While busy or done is high, start is ignored
//   and no request is queued. The end of a search is marked by done, a
//   one-cycle pulse. found, wit_i1 and wit_i2 are valid with done and stay
//   held until the next accepted start. chk_res is treated as valid in every
//   SEARCH cycle and as don't-care in all other states.
//
//   dbg_state exposes the FSM state encoding for checkers:
//   0 = IDLE, 1 = SEARCH, 2 = DONE.

module factor_search_ctrl #(
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*W-1:0]   o_in,
  output logic [2*W-1:0]   chk_o,
  output logic [W-1:0]     cand_i1,
  output logic [W-1:0]     cand_i2,
  input  logic             chk_res,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [W-1:0]     wit_i1,
  output logic [W-1:0]     wit_i2,
  output logic [2*W:0]     tries,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2*W-1:0] IDX_ONE   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] IDX_LAST  = {(2*W){1'b1}};
  localparam logic [2*W:0]   TRIES_ONE = {{(2*W){1'b0}}, 1'b1};
  localparam logic [W-1:0]   OPND_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [2*W-1:0]   r_idx;
  logic [2*W-1:0]   r_chk_o;
  logic [2*W:0]     r_tries;
  logic             r_found;
  logic [W-1:0]     r_wit_i1;
  logic [W-1:0]     r_wit_i2;

  state_t           w_state_nxt;
  logic [2*W-1:0]   w_idx_nxt;
  logic [2*W-1:0]   w_chk_o_nxt;
  logic [2*W:0]     w_tries_nxt;
  logic             w_found_nxt;
  logic [W-1:0]     w_wit_i1_nxt;
  logic [W-1:0]     w_wit_i2_nxt;

  logic [W-1:0]     w_cand_i1;
  logic [W-1:0]     w_cand_i2;
  logic             w_eval;
  logic             w_last;

  // Split the index into its outer (i1) and inner (i2) halves.
  // The candidate is taken straight from the index register. It therefore
  // holds its last value whenever the index does not advance.
  assign w_cand_i1 = r_idx[2*W-1:W];
  assign w_cand_i2 = r_idx[W-1:0];
  assign w_last    = (r_idx == IDX_LAST);

  // Decide whether the current candidate counts as an evaluated try.
`ifdef FACTOR_SKIP_TRIVIAL_EN
  assign w_eval = (w_cand_i1 != OPND_ONE) && (w_cand_i2 != OPND_ONE);
`else
  assign w_eval = 1'b1;
`endif

  // Next-state and next-datapath logic. Every value defaults to holding.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_chk_o_nxt  = r_chk_o;
    w_tries_nxt  = r_tries;
    w_found_nxt  = r_found;
    w_wit_i1_nxt = r_wit_i1;
    w_wit_i2_nxt = r_wit_i2;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_chk_o_nxt  = o_in;
          w_idx_nxt    = '0;
          w_tries_nxt  = '0;
          w_found_nxt  = 1'b0;
          w_wit_i1_nxt = '0;
          w_wit_i2_nxt = '0;
          w_state_nxt  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_eval) begin
          w_tries_nxt = r_tries + TRIES_ONE;
        end
        if (w_eval && chk_res) begin
          w_wit_i1_nxt = w_cand_i1;
          w_wit_i2_nxt = w_cand_i2;
          w_found_nxt  = 1'b1;
          w_state_nxt  = S_DONE;
        end else if (w_last) begin
          // The terminal index ends the search, so the index never wraps.
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears them and aborts any search.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_chk_o  <= '0;
      r_tries  <= '0;
      r_found  <= 1'b0;
      r_wit_i1 <= '0;
      r_wit_i2 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_chk_o  <= w_chk_o_nxt;
      r_tries  <= w_tries_nxt;
      r_found  <= w_found_nxt;
      r_wit_i1 <= w_wit_i1_nxt;
      r_wit_i2 <= w_wit_i2_nxt;
    end
  end

  assign chk_o     = r_chk_o;
  assign cand_i1   = w_cand_i1;
  assign cand_i2   = w_cand_i2;
  assign busy      = (r_state == S_SEARCH);
  assign done      = (r_state == S_DONE);
  assign found     = r_found;
  assign wit_i1    = r_wit_i1;
  assign wit_i2    = r_wit_i2;
  assign tries     = r_tries;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_factor_search_ctrl.sv
// tb_factor_search_ctrl
//   Directed bench for factor_search_ctrl with W=2. The checker is
//   modelled combinationally from the DUT's cand_* and chk_o outputs.
//   The expected values are hand-derived. Where FACTOR_SKIP_TRIVIAL_EN
//   changes tries or the result, the bench selects the expectation with
//   the same macro.
//   Cycle numbering: the cycle that ends with the start-accepting edge is
//   cycle 0. Outputs are sampled on the falling edge.

module tb_factor_search_ctrl;

  localparam int W = 2;

`ifdef FACTOR_SKIP_TRIVIAL_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [2*W-1:0]   o_in;
  logic [2*W-1:0]   chk_o;
  logic [W-1:0]     cand_i1;
  logic [W-1:0]     cand_i2;
  logic             chk_res;
  logic             busy;
  logic             done;
  logic             found;
  logic [W-1:0]     wit_i1;
  logic [W-1:0]     wit_i2;
  logic [2*W:0]     tries;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  factor_search_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .o_in      (o_in),
    .chk_o     (chk_o),
    .cand_i1   (cand_i1),
    .cand_i2   (cand_i2),
    .chk_res   (chk_res),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .wit_i1    (wit_i1),
    .wit_i2    (wit_i2),
    .tries     (tries),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational checker model: res = (i1*i2 == o)
  assign chk_res = (({{W{1'b0}}, cand_i1} * {{W{1'b0}}, cand_i2}) == chk_o);

  // Driver: start a search with target o. Optionally pulse start with
  // ign_o during cycle ign_cyc. Return the cycle in which done was seen
  // (-1 on timeout). While searching, check busy, the candidate index and
  // the captured target. The task returns at the falling edge of the done
  // cycle.
  task automatic run_search(input logic [2*W-1:0] o, input int ign_cyc,
                            input logic [2*W-1:0] ign_o, output int done_cyc);
    logic [2*W-1:0] exp_k;
    @(negedge clk);
    start = 1'b1;
    o_in  = o;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == ign_cyc) begin
        start = 1'b1;
        o_in  = ign_o;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      exp_k = 4'(n - 1);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_search cyc=%0d got=%b exp=1", n, busy);
      end
      checks++;
      if ({cand_i1, cand_i2} !== exp_k) begin
        errors++;
        $display("FAIL cand_order cyc=%0d got=%0d exp=%0d", n, {cand_i1, cand_i2}, exp_k);
      end
      checks++;
      if (chk_o !== o) begin
        errors++;
        $display("FAIL chk_o_hold cyc=%0d got=%0d exp=%0d", n, chk_o, o);
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL search_timeout o=%0d got=no_done exp=done", o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    o_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, found} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000", {busy, done, found});
    end
    checks++;
    if ({chk_o, cand_i1, cand_i2, wit_i1, wit_i2, tries} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {chk_o, cand_i1, cand_i2, wit_i1, wit_i2, tries});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got=%b exp=0", busy);
    end
  endtask

  task automatic test_o6();
    int dc;
    run_search(4'd6, 0, 4'd0, dc);
    checks++;
    if (dc != 13) begin
      errors++;
      $display("FAIL o6_cycle got=%0d exp=13", dc);
    end
    checks++;
    if ({found, wit_i1, wit_i2} !== {1'b1, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL o6_witness got=%b/%0d/%0d exp=1/2/3", found, wit_i1, wit_i2);
    end
    checks++;
    if (tries !== 5'((SKIP != 0) ? 6 : 12)) begin
      errors++;
      $display("FAIL o6_tries got=%0d exp=%0d", tries, (SKIP != 0) ? 6 : 12);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, found, wit_i1, wit_i2} !== {1'b0, 1'b0, 1'b1, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL o6_after_done got=%b exp=00_1_10_11", {done, busy, found, wit_i1, wit_i2});
    end
  endtask

  task automatic test_o3();
    int dc;
    run_search(4'd3, 0, 4'd0, dc);
    if (SKIP != 0) begin
      checks++;
      if (dc != 17 || found !== 1'b0 || tries !== 5'd9) begin
        errors++;
        $display("FAIL o3_skip got=cyc%0d/f%b/t%0d exp=cyc17/f0/t9", dc, found, tries);
      end
    end else begin
      checks++;
      if (dc != 9 || {found, wit_i1, wit_i2} !== {1'b1, 2'd1, 2'd3} || tries !== 5'd8) begin
        errors++;
        $display("FAIL o3_plain got=cyc%0d/f%b/%0d,%0d/t%0d exp=cyc9/f1/1,3/t8", dc, found, wit_i1, wit_i2, tries);
      end
    end
  endtask

  task automatic test_o0();
    int dc;
    run_search(4'd0, 0, 4'd0, dc);
    checks++;
    if (dc != 2 || {found, wit_i1, wit_i2} !== {1'b1, 2'd0, 2'd0} || tries !== 5'd1) begin
      errors++;
      $display("FAIL o0 got=cyc%0d/f%b/%0d,%0d/t%0d exp=cyc2/f1/0,0/t1", dc, found, wit_i1, wit_i2, tries);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    run_search(4'd7, 0, 4'd0, dc);
    checks++;
    if (dc != 17 || found !== 1'b0 || tries !== 5'((SKIP != 0) ? 9 : 16)) begin
      errors++;
      $display("FAIL o7_miss got=cyc%0d/f%b/t%0d exp=cyc17/f0/t%0d", dc, found, tries, (SKIP != 0) ? 9 : 16);
    end
    run_search(4'd9, 0, 4'd0, dc);
    checks++;
    if (dc != 17 || {found, wit_i1, wit_i2} !== {1'b1, 2'd3, 2'd3} || tries !== 5'((SKIP != 0) ? 9 : 16)) begin
      errors++;
      $display("FAIL o9 got=cyc%0d/f%b/%0d,%0d/t%0d exp=cyc17/f1/3,3/t%0d", dc, found, wit_i1, wit_i2, tries, (SKIP != 0) ? 9 : 16);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    @(negedge clk);
    start = 1'b1;
    o_in  = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, found, chk_o, cand_i1, cand_i2, wit_i1, wit_i2, tries} !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", {busy, done, found, chk_o, cand_i1, cand_i2, wit_i1, wit_i2, tries});
    end
    dc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dc++;
    end
    checks++;
    if (dc != 0) begin
      errors++;
      $display("FAIL reset_no_done got=%0d pulses exp=0", dc);
    end
    run_search(4'd6, 0, 4'd0, dc);
    checks++;
    if (dc != 13 || {found, wit_i1, wit_i2} !== {1'b1, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL reset_rerun got=cyc%0d/f%b/%0d,%0d exp=cyc13/f1/2,3", dc, found, wit_i1, wit_i2);
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    run_search(4'd6, 3, 4'd9, dc);
    checks++;
    if (dc != 13 || chk_o !== 4'd6 || {found, wit_i1, wit_i2} !== {1'b1, 2'd2, 2'd3}) begin
      errors++;
      $display("FAIL start_ignored got=cyc%0d/o%0d/%0d,%0d exp=cyc13/o6/2,3", dc, chk_o, wit_i1, wit_i2);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queue got=%b exp=0", busy);
    end
  endtask

  task automatic test_start_held();
    // o=0 matches at k=0. Expected {busy,done,found} for cycles 1..6.
    logic [2:0] exp_q[$];
    logic [2:0] exp_v;
    exp_q = '{3'b100, 3'b011, 3'b001, 3'b100, 3'b011, 3'b001};
    @(negedge clk);
    start = 1'b1;
    o_in  = 4'd0;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 6) start = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if ({busy, done, found} !== exp_v) begin
        errors++;
        $display("FAIL start_held cyc=%0d got=%b exp=%b", n, {busy, done, found}, exp_v);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    o_in = '0;
    test_reset();
    test_o6();
    test_o3();
    test_o0();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
